// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, types and helpers for the 16-point FFT datapath
//
// Purpose: frame geometry (points, sample width, complex word width), per-bank
// fill state, the W0..W7 twiddle constants used by every butterfly stage, and
// complex-word pack/unpack helpers.
// Ports: none (package).
package fft_pkg;

  localparam int FFT_N    = 16;
  localparam int FFT_DW   = 16;
  localparam int FFT_CW   = 2 * FFT_DW;
  localparam int FFT_IDXW = $clog2(FFT_N);

  // Twiddles W_k = exp(-j*2*pi*k/16) in Q1.14, so +1.0 == 16384 fits in DW bits.
  localparam logic signed [FFT_DW-1:0] W0_RE =  16'sd16384, W0_IM =  16'sd0;
  localparam logic signed [FFT_DW-1:0] W1_RE =  16'sd15137, W1_IM = -16'sd6270;
  localparam logic signed [FFT_DW-1:0] W2_RE =  16'sd11585, W2_IM = -16'sd11585;
  localparam logic signed [FFT_DW-1:0] W3_RE =  16'sd6270,  W3_IM = -16'sd15137;
  localparam logic signed [FFT_DW-1:0] W4_RE =  16'sd0,     W4_IM = -16'sd16384;
  localparam logic signed [FFT_DW-1:0] W5_RE = -16'sd6270,  W5_IM = -16'sd15137;
  localparam logic signed [FFT_DW-1:0] W6_RE = -16'sd11585, W6_IM = -16'sd11585;
  localparam logic signed [FFT_DW-1:0] W7_RE = -16'sd15137, W7_IM = -16'sd6270;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_t;

  // Complex word layout: real part in the upper half, imaginary in the lower.
  function automatic logic [FFT_CW-1:0] cplx_pack(input logic [FFT_DW-1:0] re,
                                                  input logic [FFT_DW-1:0] im);
    return {re, im};
  endfunction

  function automatic logic [FFT_DW-1:0] cplx_re(input logic [FFT_CW-1:0] w);
    return w[FFT_CW-1:FFT_DW];
  endfunction

  function automatic logic [FFT_DW-1:0] cplx_im(input logic [FFT_CW-1:0] w);
    return w[FFT_DW-1:0];
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one N-word complex frame register bank with fill state
//
// Purpose: holds one frame of N complex words, written one word at a time and
// read out in parallel. Tracks EMPTY/FILLING/FULL; a FULL bank ignores writes
// so a pending frame can never be overwritten.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (contents and state cleared)
//   wr_en        write wr_data into word wr_idx (ignored while FULL)
//   wr_idx       target word index
//   wr_data      complex word to store
//   set_full     mark the bank FULL (asserted with the write of the last word)
//   clr_full     frame consumed, bank returns to EMPTY
//   full         bank holds a complete frame
//   frame        all N words, word i at [CW*i +: CW]
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = FFT_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_idx,
  input  logic [2*DW-1:0]        wr_data,
  input  logic                   set_full,
  input  logic                   clr_full,
  output logic                   full,
  output logic [N*2*DW-1:0]      frame
);

  localparam int CW = 2 * DW;

  bank_state_t       state;
  logic [CW-1:0]     mem [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BANK_EMPTY;
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en && state != BANK_FULL) begin
        mem[wr_idx] <= wr_data;
      end
      case (state)
        BANK_EMPTY: begin
          if (set_full)   state <= BANK_FULL;
          else if (wr_en) state <= BANK_FILLING;
        end
        BANK_FILLING: begin
          if (set_full) state <= BANK_FULL;
        end
        BANK_FULL: begin
          if (clr_full) state <= BANK_EMPTY;
        end
        default: state <= BANK_EMPTY;
      endcase
    end
  end

  assign full = (state == BANK_FULL);

  for (genvar g = 0; g < N; g++) begin : g_frame
    assign frame[g*CW +: CW] = mem[g];
  end

endmodule

// File: rtl/fft_input_buffer.sv
// rtl/fft_input_buffer.sv - serial-to-parallel ping-pong frame buffer ahead of fft_stage1
//
// Purpose: accepts one real sample per cycle, packs N samples into a frame of
// complex words {sample, 0} and presents the frame in parallel, held stable,
// until downstream consumes it. Two banks let the next frame fill meanwhile.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     in_data valid this cycle
//   in_ready     write bank is not FULL (registered state only)
//   in_data      signed real sample
//   out_valid    read bank holds a complete frame
//   out_ready    downstream consumes the frame this cycle
//   out_frame    word i at [2*DW*i +: 2*DW] = {sample_i, 0}
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = FFT_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*2*DW-1:0]   out_frame
);

  localparam int IDXW = $clog2(N);
  localparam int CW   = 2 * DW;

  logic              wr_bank;
  logic              rd_bank;
  logic [IDXW-1:0]   wr_idx;

  logic [1:0]        bank_full;
  logic [N*CW-1:0]   bank_frame [2];

  logic              in_xfer;
  logic              out_xfer;
  logic              last_word;

  // Handshakes depend only on registered bank state, never on in_valid/in_data.
  assign in_ready  = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign out_frame = bank_frame[rd_bank];

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_word = (wr_idx == IDXW'(N - 1));

  // Write and read sides act on different banks (the write bank is never FULL
  // while accepting, the read bank is FULL when consumed), so a fill-complete
  // and a consume in the same cycle both land.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .N  (N),
      .DW (DW)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (in_xfer && (wr_bank == 1'(b))),
      .wr_idx   (wr_idx),
      .wr_data  ({in_data, {DW{1'b0}}}),
      .set_full (in_xfer && last_word && (wr_bank == 1'(b))),
      .clr_full (out_xfer && (rd_bank == 1'(b))),
      .full     (bank_full[b]),
      .frame    (bank_frame[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (in_xfer) begin
        if (last_word) begin
          wr_idx  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_idx  <= wr_idx + 1'b1;
        end
      end
      if (out_xfer) begin
        rd_bank <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// tb/tb_fft_input_buffer.sv - scoreboard bench for fft_input_buffer
module tb_fft_input_buffer;
  import fft_pkg::*;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int FW = N * 2 * DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [FW-1:0]  out_frame;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0]  sb [$];
  logic [FW-1:0]  cur;
  int             idx;
  int             pulses;
  int             accepted;

  always #5 clk = ~clk;

  fft_input_buffer #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_frame (out_frame)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check against the model, then let the
  // rising edge act. The model: queue of complete frames (at most two banks)
  // plus the frame currently being assembled.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    logic acc;
    logic pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    chk("in_ready",  FW'(in_ready),  FW'(sb.size() < 2));
    chk("out_valid", FW'(out_valid), FW'(sb.size() > 0));
    if (sb.size() > 0) chk("out_frame", out_frame, sb[0]);
    if (out_valid === 1'b1) pulses++;
    acc = v && (sb.size() < 2);
    pop = r && (sb.size() > 0);
    if (pop) void'(sb.pop_front());
    if (acc) begin
      accepted++;
      cur[32*idx +: 32] = {d, 16'h0000};
      idx++;
      if (idx == N) begin
        sb.push_back(cur);
        cur = '0;
        idx = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cur       = '0;
    idx       = 0;
    pulses    = 0;
    accepted  = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready",  FW'(in_ready),  FW'(1));
    chk("reset_out_valid", FW'(out_valid), FW'(0));
    chk("reset_out_frame", out_frame, '0);
    rst_n = 1'b1;

    // Frame 1: samples 1..16, nobody consuming.
    for (int i = 0; i < N; i++) cycle(1'b1, DW'(i + 1), 1'b0);
    #1;
    chk("f1_out_valid", FW'(out_valid), FW'(1));
    chk("f1_word0",  FW'(out_frame[31:0]),    FW'(32'h0001_0000));
    chk("f1_word15", FW'(out_frame[511:480]), FW'(32'h0010_0000));

    // Frame 2: samples -16..-1 fill the second bank, then both are full.
    for (int i = 0; i < N; i++) cycle(1'b1, DW'(i - 16), 1'b0);
    #1;
    chk("both_full_in_ready", FW'(in_ready), FW'(0));
    cycle(1'b1, 16'h7777, 1'b0);
    cycle(1'b1, 16'h7777, 1'b0);
    #1;
    chk("held_f1_word0", FW'(out_frame[31:0]), FW'(32'h0001_0000));

    // Consume frame 1 for one cycle.
    cycle(1'b0, '0, 1'b1);
    #1;
    chk("f2_word0",      FW'(out_frame[31:0]), FW'(32'hFFF0_0000));
    chk("after_consume_in_ready", FW'(in_ready), FW'(1));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Sustained stream: 4 frames, one out_valid cycle per frame.
    pulses = 0;
    for (int i = 0; i < 4 * N; i++) cycle(1'b1, DW'($urandom), 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("stream_pulses", FW'(pulses), FW'(4));

    // Random input gaps and random consumer back-pressure.
    accepted = 0;
    for (int c = 0; c < 2000 && accepted < 3 * N; c++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    chk("random_accepted", FW'(accepted), FW'(3 * N));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    #1;
    chk("random_drained", FW'(out_valid), FW'(0));

    // Reset mid-frame: partial frame must be discarded.
    for (int i = 0; i < 7; i++) cycle(1'b1, DW'(100 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready",  FW'(in_ready),  FW'(1));
    chk("midreset_out_valid", FW'(out_valid), FW'(0));
    chk("midreset_out_frame", out_frame, '0);
    sb.delete();
    cur = '0;
    idx = 0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < N; i++) cycle(1'b1, DW'(200 + i), 1'b0);
    #1;
    chk("post_reset_word0",  FW'(out_frame[31:0]),    FW'(32'h00C8_0000));
    chk("post_reset_word15", FW'(out_frame[511:480]), FW'(32'h00D7_0000));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
